// File: rtl/dc_canceller_if.sv
// Internal register bus used by the baseband blocks: word address, write/read strobes,
// registered read data returned one cycle after the read strobe.
interface intbus_interf;
    logic [31:0] addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport slave  (input addr, wr, rd, wdata, output rdata);
    modport master (output addr, wr, rd, wdata, input rdata);
endinterface

// File: rtl/dc_canceller.sv
// I/Q DC offset canceller: leaky-integrator DC estimate per rail, two-phase acquisition.
// Define DC_CANCEL_SAT_CNT_EN to build the output saturation counter (STAT[31:16]).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_BYPASS | EN=0: accumulators held at 0, samples pass through unchanged
//   S_ACQ    | fast loop (K_ACQ) for ACQ_LEN accepted samples
//   S_TRK    | slow tracking loop (K_TRK) until EN=0 or CLR
module dc_canceller #(
    parameter int unsigned BASEADDR = 0,
    parameter int          WIDTH    = 12,
    parameter int          AWIDTH   = 16,
    parameter int          ACQ_LEN  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    intbus_interf.slave             bus,
    input  logic signed [WIDTH-1:0] i_in,
    input  logic signed [WIDTH-1:0] q_in,
    input  logic                    we,
    output logic signed [WIDTH-1:0] i_out,
    output logic signed [WIDTH-1:0] q_out,
    output logic                    valid
);
    localparam int ACC_W = WIDTH + AWIDTH + 1;
    localparam int CNT_W = $clog2(ACQ_LEN + 1);

    localparam logic signed [WIDTH+1:0] Y_MAX   = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] Y_MIN   = {3'b111, {(WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   HALF    = {{(ACC_W-AWIDTH+1){1'b0}}, 1'b1, {(AWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_BYPASS = 2'd0, S_ACQ = 2'd1, S_TRK = 2'd2} state_t;

    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WIDTH+1:0] v);
        if (v > Y_MAX) return Y_MAX[WIDTH-1:0];
        if (v < Y_MIN) return Y_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] dc_est(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] r;
        r = {acc[ACC_W-1], acc} + HALF;
        return sat_w(r[ACC_W:AWIDTH]);
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_next(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] dc,
        input logic [3:0]              k
    );
        logic signed [WIDTH:0]   err;
        logic signed [ACC_W-1:0] step;
        logic signed [ACC_W:0]   sum;
        err  = {x[WIDTH-1], x} - {dc[WIDTH-1], dc};
        step = {err, {AWIDTH{1'b0}}};
        step = step >>> k;
        sum  = {acc[ACC_W-1], acc} + {step[ACC_W-1], step};
        if (sum[ACC_W] != sum[ACC_W-1]) return sum[ACC_W] ? ACC_MIN : ACC_MAX;
        return sum[ACC_W-1:0];
    endfunction

    logic                    cfg_en, cfg_freeze;
    logic [3:0]              cfg_k_acq, cfg_k_trk;
    logic [31:0]             offs;
    logic                    wr_cfg, clr;
    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        acq_cnt;
    logic                    acq_cnt_en, loop_run, hold_zero;
    logic [3:0]              k_sel;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic signed [WIDTH-1:0] dc_i, dc_q;
    logic signed [WIDTH-1:0] x1_i, x1_q, dc1_i, dc1_q;
    logic                    v1;
    logic signed [WIDTH:0]   diff_i, diff_q;
    logic [15:0]             sat_cnt;
    logic                    unused_wdata;

    assign offs         = bus.addr - BASEADDR;
    assign wr_cfg       = bus.wr && (offs == 32'd0);
    assign clr          = wr_cfg && bus.wdata[31];
    assign unused_wdata = ^{bus.wdata[30:12], bus.wdata[3:2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_en     <= 1'b0;
            cfg_freeze <= 1'b0;
            cfg_k_acq  <= '0;
            cfg_k_trk  <= '0;
        end else if (wr_cfg) begin
            cfg_en     <= bus.wdata[0];
            cfg_freeze <= bus.wdata[1];
            cfg_k_acq  <= bus.wdata[7:4];
            cfg_k_trk  <= bus.wdata[11:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_BYPASS;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BYPASS: if (cfg_en) state_nxt = S_ACQ;
            S_ACQ: begin
                if (!cfg_en)                                      state_nxt = S_BYPASS;
                else if (clr)                                     state_nxt = S_ACQ;
                else if (we && acq_cnt == CNT_W'(ACQ_LEN - 1))    state_nxt = S_TRK;
            end
            S_TRK: begin
                if (!cfg_en)  state_nxt = S_BYPASS;
                else if (clr) state_nxt = S_ACQ;
            end
            default: state_nxt = S_BYPASS;
        endcase
    end

    always_comb begin
        k_sel      = cfg_k_acq;
        acq_cnt_en = 1'b0;
        loop_run   = 1'b0;
        case (state)
            S_ACQ: begin
                acq_cnt_en = 1'b1;
                loop_run   = 1'b1;
            end
            S_TRK: begin
                k_sel    = cfg_k_trk;
                loop_run = 1'b1;
            end
            default: ;
        endcase
    end

    // A disabled or just-cleared loop contributes no correction to the sample in flight.
    assign hold_zero = clr || !cfg_en || !loop_run;
    assign dc_i      = dc_est(acc_i);
    assign dc_q      = dc_est(acc_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acq_cnt <= '0;
            acc_i   <= '0;
            acc_q   <= '0;
        end else begin
            if (clr || !acq_cnt_en) acq_cnt <= '0;
            else if (we)            acq_cnt <= acq_cnt + 1'b1;

            if (hold_zero) begin
                acc_i <= '0;
                acc_q <= '0;
            end else if (we && !cfg_freeze) begin
                acc_i <= acc_next(acc_i, i_in, dc_i, k_sel);
                acc_q <= acc_next(acc_q, q_in, dc_q, k_sel);
            end
        end
    end

    assign diff_i = {x1_i[WIDTH-1], x1_i} - {dc1_i[WIDTH-1], dc1_i};
    assign diff_q = {x1_q[WIDTH-1], x1_q} - {dc1_q[WIDTH-1], dc1_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_i  <= '0;
            x1_q  <= '0;
            dc1_i <= '0;
            dc1_q <= '0;
            v1    <= 1'b0;
            i_out <= '0;
            q_out <= '0;
            valid <= 1'b0;
        end else begin
            x1_i  <= i_in;
            x1_q  <= q_in;
            dc1_i <= hold_zero ? '0 : dc_i;
            dc1_q <= hold_zero ? '0 : dc_q;
            v1    <= we;
            i_out <= sat_w({diff_i[WIDTH], diff_i});
            q_out <= sat_w({diff_q[WIDTH], diff_q});
            valid <= v1;
        end
    end

`ifdef DC_CANCEL_SAT_CNT_EN
    logic clip;
    assign clip = ({diff_i[WIDTH], diff_i} > Y_MAX) || ({diff_i[WIDTH], diff_i} < Y_MIN) ||
                  ({diff_q[WIDTH], diff_q} > Y_MAX) || ({diff_q[WIDTH], diff_q} < Y_MIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      sat_cnt <= '0;
        else if (v1 && clip && sat_cnt != 16'hFFFF)   sat_cnt <= sat_cnt + 16'd1;
    end
`else
    assign sat_cnt = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdata <= '0;
        end else if (bus.rd) begin
            case (offs)
                32'd0:   bus.rdata <= {20'd0, cfg_k_trk, cfg_k_acq, 2'b00, cfg_freeze, cfg_en};
                32'd1:   bus.rdata <= {{(32-WIDTH){dc_i[WIDTH-1]}}, dc_i};
                32'd2:   bus.rdata <= {{(32-WIDTH){dc_q[WIDTH-1]}}, dc_q};
                32'd3:   bus.rdata <= {sat_cnt, 14'd0, state};
                default: bus.rdata <= '0;
            endcase
        end else begin
            bus.rdata <= '0;
        end
    end
endmodule

// File: tb/tb_dc_canceller.sv
// Bench for dc_canceller: random stimulus, integer reference model, queue scoreboard.
module tb_dc_canceller;
    localparam int W     = 12;
    localparam int A     = 16;
    localparam int ACQ   = 1024;
    localparam int ACC_W = W + A + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] i_in = '0;
    logic signed [W-1:0] q_in = '0;
    logic                we = 1'b0;
    logic signed [W-1:0] i_out, q_out;
    logic                valid;

    intbus_interf bus_if ();

    dc_canceller #(.BASEADDR(0), .WIDTH(W), .AWIDTH(A), .ACQ_LEN(ACQ)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .i_in (i_in),
        .q_in (q_in),
        .we   (we),
        .i_out(i_out),
        .q_out(q_out),
        .valid(valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int i; int q; int c;} exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    longint m_acc_i, m_acc_q;
    int     m_state, m_cnt, m_sat, m_kacq, m_ktrk;
    bit     m_en, m_frz;

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint clampl(longint v, longint lo, longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // DC estimate: acc / 2^A rounded half up, limited to the sample range
    function automatic longint m_dc(longint acc);
        return clampl((acc + (longint'(1) << (A - 1))) >>> A, -2048, 2047);
    endfunction

    function automatic longint m_upd(longint acc, longint x, longint dc, int k);
        return clampl(acc + (((x - dc) * (longint'(1) << A)) >>> k),
                      -(longint'(1) << (ACC_W - 1)), (longint'(1) << (ACC_W - 1)) - 1);
    endfunction

    function automatic logic [31:0] cfg_word();
        return {20'd0, 4'(m_ktrk), 4'(m_kacq), 2'b00, m_frz, m_en};
    endfunction

    function automatic longint exp_sat();
`ifdef DC_CANCEL_SAT_CNT_EN
        return m_sat;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_acc_i = 0; m_acc_q = 0; m_state = 0; m_cnt = 0; m_sat = 0;
        m_kacq = 0; m_ktrk = 0; m_en = 0; m_frz = 0;
    endtask

    task automatic model_clr();
        m_acc_i = 0;
        m_acc_q = 0;
        m_cnt   = 0;
        if (m_en && m_state != 0) m_state = 1;
    endtask

    task automatic model_sample(int xi, int xq, output int yi, output int yq);
        longint di = 0, dq = 0, ri, rq;
        int k;
        if (m_state != 0) begin
            k  = (m_state == 2) ? m_ktrk : m_kacq;
            di = m_dc(m_acc_i);
            dq = m_dc(m_acc_q);
            if (!m_frz) begin
                m_acc_i = m_upd(m_acc_i, xi, di, k);
                m_acc_q = m_upd(m_acc_q, xq, dq, k);
            end
            if (m_state == 1) begin
                m_cnt++;
                if (m_cnt == ACQ) m_state = 2;
            end
        end
        ri = xi - di;
        rq = xq - dq;
        yi = int'(clampl(ri, -2048, 2047));
        yq = int'(clampl(rq, -2048, 2047));
        if ((ri != yi || rq != yq) && m_sat < 65535) m_sat++;
    endtask

    task automatic drive(bit w, int xi, int xq, bit clr);
        int yi, yq;
        exp_t e;
        @(negedge clk);
        i_in          = xi[W-1:0];
        q_in          = xq[W-1:0];
        we            = w;
        bus_if.rd     = 1'b0;
        bus_if.wr     = clr;
        bus_if.addr   = 32'd0;
        bus_if.wdata  = cfg_word() | (clr ? 32'h8000_0000 : 32'h0);
        if (clr) begin
            model_clr();
            yi = xi;
            yq = xq;
        end else if (w) begin
            model_sample(xi, xq, yi, yq);
        end
        if (w) begin
            e.i = yi; e.q = yq; e.c = cyc + 2;
            exp_q.push_back(e);
        end
    endtask

    task automatic write_cfg(bit en, bit frz, int ka, int kt);
        @(negedge clk);
        we           = 1'b0;
        bus_if.rd    = 1'b0;
        bus_if.wr    = 1'b1;
        bus_if.addr  = 32'd0;
        bus_if.wdata = {20'd0, 4'(kt), 4'(ka), 2'b00, frz, en};
        @(negedge clk);
        bus_if.wr = 1'b0;
        m_en = en; m_frz = frz; m_kacq = ka; m_ktrk = kt;
        if (!en) begin
            m_state = 0; m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_cnt = 0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic read_reg(int off, output logic [31:0] v);
        @(negedge clk);
        we          = 1'b0;
        bus_if.wr   = 1'b0;
        bus_if.rd   = 1'b1;
        bus_if.addr = 32'(off);
        @(posedge clk);
        #1;
        v         = bus_if.rdata;
        bus_if.rd = 1'b0;
    endtask

    function automatic int rnd12();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // Monitor: every valid output must match the oldest expected sample, at the expected cycle
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got i_out=%0d q_out=%0d, expected no output", i_out, q_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("i_out", i_out, e.i);
                check("q_out", q_out, e.q);
                check("latency_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        logic [31:0] rv;
        longint      dcv;
        bus_if.addr = '0; bus_if.wr = 1'b0; bus_if.rd = 1'b0; bus_if.wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_i_out", i_out, 0);
        check("rst_q_out", q_out, 0);
        check("rst_valid", valid, 0);
        rst = 1'b0;

        read_reg(0, rv); check("rst_cfg", rv, 0);
        read_reg(3, rv); check("rst_stat", rv, 0);
        read_reg(1, rv); check("rst_dc_i", rv, 0);

        // Bypass: output equals input two cycles later
        for (int n = 0; n < 60; n++) drive(1'($urandom_range(0, 1)), rnd12(), rnd12(), 1'b0);
        read_reg(3, rv); check("bypass_state", rv[1:0], 0);

        // Acquisition on constant DC with we toggling every cycle
        write_cfg(1'b1, 1'b0, 4, 10);
        read_reg(0, rv); check("cfg_readback", rv, 32'h0000_0A41);
        read_reg(3, rv); check("acq_state", rv[1:0], 1);
        for (int n = 0; n < ACQ - 1; n++) begin
            drive(1'b1, 300, -200, 1'b0);
            drive(1'b0, 300, -200, 1'b0);
        end
        read_reg(3, rv); check("acq_before_last", rv[1:0], 1);
        drive(1'b1, 300, -200, 1'b0);
        read_reg(3, rv); check("trk_after_last", rv[1:0], 2);
        read_reg(1, rv); dcv = longint'($signed(rv));
        check("dc_i_model", dcv, m_dc(m_acc_i));
        check("dc_i_near_300", (dcv >= 299 && dcv <= 301), 1);
        read_reg(2, rv); dcv = longint'($signed(rv));
        check("dc_q_model", dcv, m_dc(m_acc_q));
        check("dc_q_near_m200", (dcv >= -201 && dcv <= -199), 1);

        // Tracking with full-scale random input (saturates against the offset)
        for (int n = 0; n < 400; n++) drive(1'($urandom_range(0, 3) != 0), rnd12(), rnd12(), 1'b0);
        read_reg(3, rv);
        check("trk_state", rv[1:0], 2);
        check("trk_sat_cnt", rv[31:16], exp_sat());

        // Freeze, then step the input DC
        write_cfg(1'b1, 1'b1, 4, 10);
        for (int n = 0; n < 60; n++) drive(1'b1, -500, -200, 1'b0);
        read_reg(1, rv); check("frozen_dc_i", longint'($signed(rv)), m_dc(m_acc_i));
        write_cfg(1'b1, 1'b0, 4, 6);
        for (int n = 0; n < 800; n++) drive(1'b1, -500, -200, 1'b0);
        read_reg(1, rv); dcv = longint'($signed(rv));
        check("reconv_dc_i", dcv, m_dc(m_acc_i));
        check("reconv_near_m500", (dcv >= -501 && dcv <= -499), 1);

        // CLR together with an accepted sample: sample passes with dc=0, loop restarts
        drive(1'b1, 1000, -1000, 1'b1);
        read_reg(1, rv); check("clr_dc_i", rv, 0);
        read_reg(3, rv); check("clr_state", rv[1:0], 1);
        read_reg(0, rv); check("clr_self_clears", rv[31], 0);

        // Second acquisition on full-scale random data
        for (int n = 0; n < 4000 && m_state != 2; n++)
            drive(1'($urandom_range(0, 3) != 0), rnd12(), rnd12(), 1'b0);
        read_reg(3, rv);
        check("acq2_state", rv[1:0], 2);
        check("acq2_sat_cnt", rv[31:16], exp_sat());

        // Asynchronous reset mid-stream
        for (int n = 0; n < 20; n++) drive(1'b1, rnd12(), rnd12(), 1'b0);
        #2;
        rst = 1'b1;
        we  = 1'b0;
        #1;
        check("midrst_i_out", i_out, 0);
        check("midrst_q_out", q_out, 0);
        check("midrst_valid", valid, 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        read_reg(0, rv); check("midrst_cfg", rv, 0);
        read_reg(3, rv); check("midrst_stat", rv, 0);
        read_reg(1, rv); check("midrst_dc_i", rv, 0);
        for (int n = 0; n < 10; n++) drive(1'b1, rnd12(), rnd12(), 1'b0);
        repeat (4) drive(1'b0, 0, 0, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
